ad5542_dac_sched: RTL and testbench
===================================

# ad5542_dac_sched

Write scheduler for the single AD5542 serial DAC writer. Up to `NREQ` independent requesters post 16-bit DAC codes. The block holds the latest code per requester and grants the shared writer round-robin. It issues one-cycle `wr_data_en` starts, waits for the writer's `wr_data_end`, enforces a post-write gap, and flags writer timeouts.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `GAP_CYCLES`, 8: idle cycles after end-of-write before the next start; must be ≥5 so the writer has returned to idle.
- `TIMEOUT_CYCLES`, 255: max cycles from start to `wr_data_end` (8-bit counter).

Ports:
- `clk` in 1: system clock; only clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: one-cycle pulse per requester; loads that requester's pending slot.
- `req_data` in NREQ*16: code for requester i at bits [16i+15:16i]; sampled with `req_valid[i]`.
- `req_done` out NREQ: one-cycle pulse when requester i's code has been written.
- `req_drop` out NREQ: one-cycle pulse when a still-pending code of requester i is overwritten.
- `timeout_err` out 1: one-cycle pulse when a write times out.
- `busy` out 1: high in any state other than IDLE.
- `wr_data_en` out 1: one-cycle start strobe to the writer.
- `wr_data` out 16: code to the writer; valid with `wr_data_en`, held until the next grant.
- `wr_data_end` in 1: end-of-write pulse from the writer.

## Operation
- Per requester i, the block keeps a pending bit `pend[i]` and a 16-bit slot `slot[i]`.
- When `req_valid[i]` is high:
  - `slot[i]` takes the new code and `pend[i]` is set.
  - If `pend[i]` was already set and i is not being granted that cycle, `req_drop[i]` pulses. Latest value wins.
- FSM states are IDLE, ISSUE, WAIT and GAP.
- **IDLE**: if any `pend` bit is set, grant the first set bit searching upward (with wrap) from `last+1`. Then:
  - Latch `wr_data` from the granted slot.
  - Clear the granted pend bit.
  - Store the grant index in `last`.
  - Go to ISSUE.
- **ISSUE**: `wr_data_en` = 1 for this cycle only; clear the timeout counter; go to WAIT.
- **WAIT**:
  - On `wr_data_end`: pulse `req_done[grant]` next cycle and go to GAP.
  - If the counter reaches `TIMEOUT_CYCLES` first: pulse `timeout_err`, drop the code (no `req_done`, not re-pended), and go to GAP.
- **GAP**: count `GAP_CYCLES`, then go to IDLE.
- **Simultaneous `req_valid[i]` and grant of i**: the granted (old) code is written. The set wins over the clear, so the new code stays pending. No drop pulse.
- `wr_data_end` outside WAIT is ignored.
- Reset values: all `pend` = 0, slots = 0, `last` = NREQ-1 (so requester 0 has first priority), state IDLE, every output 0.
- Reset mid-write: the FSM returns to IDLE and all pending codes are lost. The writer shares `rst`, so it aborts as well.

## Timing
- `req_valid[i]` in cycle t with block idle → `pend[i]` = 1 at t+1 → `wr_data_en` = 1 in cycle t+2. This is the minimum start latency.
- `wr_data_end` in cycle e → `req_done` in cycle e+1 → GAP spans e+1..e+GAP_CYCLES → the next `wr_data_en` is no earlier than e+GAP_CYCLES+2.
- Starts are never closer than one writer transaction plus `GAP_CYCLES`.
- The timeout counter is 8 bits and saturates; it does not wrap.
- All outputs are registered.

## Structure
- Shared package `ad5542_pkg` holds:
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2, GAP=3);
  - `DAC_W` = 16;
  - default `GAP_CYCLES` and `TIMEOUT_CYCLES`.
- Sub-module `ad5542_rr_arb` is combinational round-robin pick.
  - Inputs: `pend` and `last`.
  - Outputs: `grant_valid` and `grant_idx`.
- Top level: pending slots, FSM, counters.
- The top level is instantiated next to `ad5542_spi_wr` and wired port-to-port.

## Test plan
- **Single write:** `req_valid[0]` with 0x8000 at t, with a writer model giving `wr_data_end` at +70 → `wr_data_en` at t+2 with `wr_data`=0x8000, then `req_done[0]` one cycle after end, `busy` low after the gap.
- **Round-robin:** requesters 0..3 post 0x1111, 0x2222, 0x3333, 0x4444 in the same cycle → writes in order 0,1,2,3. Then requester 0 and 2 re-post → order 0, 2 (continues from `last`=3).
- **Overwrite:** requester 1 posts 0x0AAA then 0x0BBB while requester 0 is writing → `req_drop[1]` pulses once, only 0x0BBB is written.
- **Simultaneous valid and grant:** requester 2 posts 0x0CCC in its grant cycle while holding 0x0DDD → 0x0DDD is written, then 0x0CCC is written next. No drop pulse.
- **Timeout:** the writer model never returns `wr_data_end` → `timeout_err` pulses `TIMEOUT_CYCLES` cycles after the start, with no `req_done`. The next pending request proceeds after the gap.
- **Reset mid-WAIT:** assert `rst` during a write → all outputs go to 0, no `req_done`. After reset a fresh request starts with t+2 latency.

Source files
------------

// File: rtl/ad5542_pkg.sv
// Shared constants for the AD5542 write scheduler: state encoding, code width,
// default timing parameters and the saturating timeout increment.
package ad5542_pkg;

    localparam int unsigned DAC_W              = 16;
    localparam int unsigned GAP_CYCLES_DEF     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam int unsigned TMO_W              = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    function automatic logic [TMO_W-1:0] tmo_sat_inc(input logic [TMO_W-1:0] v);
        return (v == '1) ? v : v + TMO_W'(1);
    endfunction

endpackage

// File: rtl/ad5542_rr_arb.sv
// Combinational round-robin pick: first set pend bit searching upward from last+1 with wrap.
module ad5542_rr_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  pend,
    input  logic [IDX_W-1:0] last,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest set bit is the last one written.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((32'(last) + k) % NREQ);
            if (pend[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ad5542_dac_sched.sv
// Write scheduler for the shared AD5542 writer: latest-code slots per requester,
// round-robin grant, start strobe, end-of-write wait with timeout, and post-write gap.
module ad5542_dac_sched
    import ad5542_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DAC_W-1:0] req_data,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       req_drop,
    output logic                  timeout_err,
    output logic                  busy,
    output logic                  wr_data_en,
    output logic [DAC_W-1:0]      wr_data,
    input  logic                  wr_data_end
);

    localparam int unsigned      IDX_W    = $clog2(NREQ);
    localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYCLES);

    logic [1:0]                  state_q, state_d;
    logic [NREQ-1:0]             pend_q, pend_d;
    logic [NREQ-1:0][DAC_W-1:0]  slot_q, slot_d;
    logic [IDX_W-1:0]            last_q, last_d;
    logic [DAC_W-1:0]            wr_data_q, wr_data_d;
    logic                        wr_en_q, wr_en_d;
    logic [NREQ-1:0]             done_q, done_d;
    logic [NREQ-1:0]             drop_q, drop_d;
    logic                        tmo_err_q, tmo_err_d;
    logic                        busy_q, busy_d;
    logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;

    logic                        grant_valid;
    logic [IDX_W-1:0]            grant_idx;
    logic                        grant_fire;

    ad5542_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .pend        (pend_q),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        slot_d     = slot_q;
        last_d     = last_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        done_d     = '0;
        drop_d     = '0;
        tmo_err_d  = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        grant_fire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    grant_fire = 1'b1;
                    wr_data_d  = slot_q[grant_idx];
                    last_d     = grant_idx;
                    wr_en_d    = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            // Counter holds cycles elapsed since the start strobe.
            ST_ISSUE: begin
                tmo_cnt_d = TMO_W'(1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_sat_inc(tmo_cnt_q);
                if (wr_data_end) begin
                    done_d[last_q] = 1'b1;
                    gap_cnt_d      = '0;
                    state_d        = ST_GAP;
                end else if (tmo_cnt_d == TMO_LIM) begin
                    tmo_err_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear before set: a post in the grant cycle keeps the new code pending.
        if (grant_fire) begin
            pend_d[grant_idx] = 1'b0;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                slot_d[i] = req_data[i*DAC_W +: DAC_W];
                pend_d[i] = 1'b1;
                drop_d[i] = pend_q[i] && !(grant_fire && (grant_idx == IDX_W'(i)));
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            slot_q    <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= '0;
            drop_q    <= '0;
            tmo_err_q <= 1'b0;
            busy_q    <= 1'b0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            slot_q    <= slot_d;
            last_q    <= last_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            tmo_err_q <= tmo_err_d;
            busy_q    <= busy_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign req_done    = done_q;
    assign req_drop    = drop_q;
    assign timeout_err = tmo_err_q;
    assign busy        = busy_q;
    assign wr_data_en  = wr_en_q;
    assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_ad5542_dac_sched.sv
// Scoreboard bench for ad5542_dac_sched with a behavioural writer that ends each
// write WR_LAT cycles after the start, or never for HANG_CODE.
module tb_ad5542_dac_sched;

    localparam int          NREQ      = 4;
    localparam int          G         = 8;
    localparam int          T         = 255;
    localparam int          WR_LAT    = 70;
    localparam logic [15:0] HANG_CODE = 16'h0EEE;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] data;
        logic        hang;
    } wr_exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*16-1:0] req_data;
    logic [NREQ-1:0]  req_done;
    logic [NREQ-1:0]  req_drop;
    logic             timeout_err;
    logic             busy;
    logic             wr_data_en;
    logic [15:0]      wr_data;
    logic             wr_data_end;

    ad5542_dac_sched #(
        .NREQ           (NREQ),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_done    (req_done),
        .req_drop    (req_drop),
        .timeout_err (timeout_err),
        .busy        (busy),
        .wr_data_en  (wr_data_en),
        .wr_data     (wr_data),
        .wr_data_end (wr_data_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Writer model
    int wcnt;
    initial begin
        wcnt        = 0;
        wr_data_end = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wr_data_end = 1'b0;
            if (rst) begin
                wcnt = 0;
            end else begin
                if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0) wr_data_end = 1'b1;
                end
                if (wr_data_en && wr_data != HANG_CODE) wcnt = WR_LAT;
            end
        end
    end

    // Scoreboard
    wr_exp_t    exp_wr[$];
    int         exp_drop[$];
    int         exp_done_cyc  = -1;
    logic [3:0] exp_done_mask = 4'h0;
    int         exp_tmo_cyc   = -1;
    int         next_min      = 0;
    bit         mon_en        = 1'b0;

    always @(negedge clk) begin
        wr_exp_t e;
        if (rst || !mon_en) begin
            exp_done_cyc = -1;
            exp_tmo_cyc  = -1;
            next_min     = 0;
        end else begin
            if (wr_data_en) begin
                check_eq("start_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check_eq("wr_data", 32'(wr_data), 32'(e.data));
                    check_eq("start_spacing", 32'(cyc >= next_min), 1);
                    if (e.hang) begin
                        exp_tmo_cyc = cyc + T;
                        next_min    = cyc + T + G + 1;
                    end else begin
                        exp_done_cyc  = cyc + WR_LAT + 1;
                        exp_done_mask = 4'(1) << e.idx;
                        next_min      = cyc + WR_LAT + G + 2;
                    end
                end
            end
            if (req_done != '0 || cyc == exp_done_cyc)
                check_eq("req_done", 32'(req_done), 32'((cyc == exp_done_cyc) ? exp_done_mask : 4'h0));
            if (timeout_err || cyc == exp_tmo_cyc)
                check_eq("timeout_err", 32'(timeout_err), 32'(cyc == exp_tmo_cyc));
            if (req_drop != '0) begin
                check_eq("drop_expected", 32'(exp_drop.size() != 0), 1);
                if (exp_drop.size() != 0)
                    check_eq("req_drop", 32'(req_drop), 32'(4'(1) << exp_drop.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int idx, input logic [15:0] d);
        req_valid[idx]         = 1'b1;
        req_data[idx*16 +: 16] = d;
    endtask

    task automatic expect_wr(input int idx, input logic [15:0] d);
        wr_exp_t e;
        e.idx  = 2'(idx);
        e.data = d;
        e.hang = (d == HANG_CODE);
        exp_wr.push_back(e);
    endtask

    task automatic end_post();
        step();
        req_valid = '0;
    endtask

    task automatic wait_start(output int c);
        int n = 0;
        while (!wr_data_en && n < 600) begin
            step();
            n++;
        end
        c = cyc;
        check_eq("start_seen", 32'(wr_data_en), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        step();
        while ((busy || exp_wr.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        check_eq("idle_reached", 32'(!busy && exp_wr.size() == 0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_wr_en", 32'(wr_data_en), 0);
        check_eq("rst_wr_data", 32'(wr_data), 0);
        check_eq("rst_done", 32'(req_done), 0);
        check_eq("rst_drop", 32'(req_drop), 0);
        check_eq("rst_tmo", 32'(timeout_err), 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int s;
        logic [15:0] rr_codes [4];
        rr_codes = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        step();
        do_reset();
        mon_en = 1'b1;

        // Single write: start latency and gap length
        step();
        t0 = cyc;
        post(0, 16'h8000);
        expect_wr(0, 16'h8000);
        end_post();
        wait_start(s);
        check_eq("start_latency", 32'(s - t0), 2);
        while (cyc < s + WR_LAT + G) step();
        check_eq("busy_in_gap", 32'(busy), 1);
        step();
        check_eq("busy_after_gap", 32'(busy), 0);

        // Round-robin from reset priority, then continuing from last
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            post(i, rr_codes[i]);
            expect_wr(i, rr_codes[i]);
        end
        end_post();
        wait_idle();
        step();
        post(0, 16'h5555);
        post(2, 16'h6666);
        expect_wr(0, 16'h5555);
        expect_wr(2, 16'h6666);
        end_post();
        wait_idle();

        // Overwrite of a still-pending code
        step();
        post(0, 16'h0123);
        expect_wr(0, 16'h0123);
        end_post();
        wait_start(s);
        repeat (5) step();
        post(1, 16'h0AAA);
        end_post();
        post(1, 16'h0BBB);
        expect_wr(1, 16'h0BBB);
        exp_drop.push_back(1);
        end_post();
        wait_idle();

        // Post landing in the grant cycle of the same requester
        step();
        t0 = cyc;
        post(2, 16'h0DDD);
        expect_wr(2, 16'h0DDD);
        end_post();
        post(2, 16'h0CCC);
        expect_wr(2, 16'h0CCC);
        end_post();
        wait_start(s);
        check_eq("grant_cycle_latency", 32'(s - t0), 2);
        wait_idle();

        // Writer timeout, then the next pending request
        step();
        post(3, HANG_CODE);
        post(0, 16'h0F0F);
        expect_wr(3, HANG_CODE);
        expect_wr(0, 16'h0F0F);
        end_post();
        wait_idle();

        // Reset during WAIT discards in-flight and pending codes
        step();
        post(1, 16'h1357);
        expect_wr(1, 16'h1357);
        end_post();
        wait_start(s);
        repeat (10) step();
        post(2, 16'h2222);
        end_post();
        do_reset();
        step();
        t0 = cyc;
        post(0, 16'h2468);
        expect_wr(0, 16'h2468);
        end_post();
        wait_start(s);
        check_eq("post_reset_latency", 32'(s - t0), 2);
        wait_idle();

        check_eq("drops_outstanding", 32'(exp_drop.size()), 0);
        check_eq("writes_outstanding", 32'(exp_wr.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
